// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder: accepts decoded fields over valid/ready, range-checks the
// immediate, packs a 32-bit instruction and writes it sequentially into instruction memory.
module instr_encoder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [63:0]       in_imm,
    output logic              imem_we,
    input  logic              imem_wready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] count,
    output logic              full
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] DepthCnt = ADDR_W'(DEPTH);

    localparam logic [2:0] FmtLdur = 3'd0;
    localparam logic [2:0] FmtStur = 3'd1;
    localparam logic [2:0] FmtCbz  = 3'd2;
    localparam logic [2:0] FmtOrr  = 3'd3;
    localparam logic [2:0] FmtB    = 3'd4;

    localparam logic [1:0] ErrRange = 2'b01;
    localparam logic [1:0] ErrFmt   = 2'b10;

    typedef enum logic [1:0] {StIdle, StCheck, StWrite, StErr} state_e;

    state_e            state_q, state_d;
    logic [2:0]        fmt_q;
    logic [4:0]        rt_q, rn_q, rm_q;
    logic [63:0]       imm_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        err_code_q, err_code_d;

    logic        accept;
    logic [31:0] enc_word;
    logic        range_ok;
    logic        fmt_ok;

    assign full       = (count_q == DepthCnt);
    assign in_ready   = (state_q == StIdle) && !full;
    assign accept     = in_valid && in_ready;
    // Decoded straight from the state register so reset drops the request asynchronously.
    assign imem_we    = (state_q == StWrite);
    assign err_valid  = (state_q == StErr);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign err_code   = err_code_q;
    assign count      = count_q;

    always_comb begin
        enc_word = '0;
        range_ok = 1'b1;
        fmt_ok   = 1'b1;
        case (fmt_q)
            FmtLdur: begin
                enc_word = {11'b11111000010, imm_q[8:0], 2'b00, rn_q, rt_q};
                range_ok = ~|imm_q[63:9];
            end
            FmtStur: begin
                enc_word = {11'b11111000000, imm_q[8:0], 2'b00, rn_q, rt_q};
                range_ok = ~|imm_q[63:9];
            end
            FmtCbz: begin
                enc_word = {8'b10110100, imm_q[18:0], rt_q};
                range_ok = (&imm_q[63:18]) | ~(|imm_q[63:18]);
            end
            FmtOrr: begin
                enc_word = {11'b10101010000, rm_q, 6'b000000, rn_q, rt_q};
            end
            FmtB: begin
                enc_word = {6'b000101, imm_q[25:0]};
                range_ok = (&imm_q[63:25]) | ~(|imm_q[63:25]);
            end
            default: fmt_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        wdata_d    = wdata_q;
        err_code_d = err_code_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StCheck;
            end
            StCheck: begin
                if (!fmt_ok) begin
                    err_code_d = ErrFmt;
                    state_d    = StErr;
                end else if (!range_ok) begin
                    err_code_d = ErrRange;
                    state_d    = StErr;
                end else begin
                    wdata_d = enc_word;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (imem_wready) begin
                    addr_d  = addr_q + ADDR_W'(4);
                    count_d = count_q + ADDR_W'(1);
                    state_d = StIdle;
                end
            end
            StErr: state_d = StIdle;
        endcase
        // Restart wins over everything, including a write accepted this same cycle.
        if (clr) begin
            state_d = StIdle;
            addr_d  = BaseAddr;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= BaseAddr;
            count_q    <= '0;
            wdata_q    <= '0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            wdata_q    <= wdata_d;
            err_code_q <= err_code_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmt_q <= '0;
            rt_q  <= '0;
            rn_q  <= '0;
            rm_q  <= '0;
            imm_q <= '0;
        end else if (accept && !clr) begin
            fmt_q <= in_fmt;
            rt_q  <= in_rt;
            rn_q  <= in_rn;
            rm_q  <= in_rm;
            imm_q <= in_imm;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (DEPTH=4 instance): scoreboard of expected
// writes/errors pushed at handshake and popped when the DUT responds.
module tb_instr_encoder;

    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_fmt = '0;
    logic [4:0]        in_rt = '0;
    logic [4:0]        in_rn = '0;
    logic [4:0]        in_rm = '0;
    logic [63:0]       in_imm = '0;
    logic              imem_we;
    logic              imem_wready = 1'b0;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              err_valid;
    logic [1:0]        err_code;
    logic [ADDR_W-1:0] count;
    logic              full;

    typedef struct {
        bit                is_err;
        logic [1:0]        code;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [ADDR_W-1:0] exp_count = '0;

    always #5 clk = ~clk;

    instr_encoder #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(0),
        .DEPTH    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fmt     (in_fmt),
        .in_rt      (in_rt),
        .in_rn      (in_rn),
        .in_rm      (in_rm),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_wready(imem_wready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .count      (count),
        .full       (full)
    );

    task automatic test_reset();
        #1;
        checks++;
        if ({in_ready, imem_we, err_valid, full} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 1000", {in_ready, imem_we, err_valid, full});
        end
        checks++;
        if (imem_addr !== '0 || imem_wdata !== '0 || count !== '0 || err_code !== '0) begin
            errors++;
            $display("FAIL reset_values: got addr=%h wdata=%h count=%0d code=%b want all zero",
                     imem_addr, imem_wdata, count, err_code);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_txn(input string name, input logic [2:0] fmt, input logic [4:0] rt,
                          input logic [4:0] rn, input logic [4:0] rm, input logic [63:0] imm,
                          input bit exp_err, input logic [1:0] exp_code,
                          input logic [31:0] exp_data, input int hold);
        exp_t e;
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: got in_ready=0 want 1", name);
            return;
        end
        sb.push_back('{exp_err, exp_code, exp_addr, exp_data});
        in_valid = 1'b1;
        in_fmt   = fmt;
        in_rt    = rt;
        in_rn    = rn;
        in_rm    = rm;
        in_imm   = imm;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_fmt   = 3'($urandom);
        in_rt    = 5'($urandom);
        in_imm   = {$urandom, $urandom};
        checks++;
        if (imem_we !== 1'b0 || in_ready !== 1'b0 || err_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_check_cycle: got we=%b rdy=%b err=%b want 0 0 0",
                     name, imem_we, in_ready, err_valid);
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.is_err) begin
            checks++;
            if (err_valid !== 1'b1 || err_code !== e.code || imem_we !== 1'b0) begin
                errors++;
                $display("FAIL %s_err: got ev=%b code=%b we=%b want 1 %b 0",
                         name, err_valid, err_code, imem_we, e.code);
            end
            @(posedge clk);
            #1;
            checks++;
            if (err_valid !== 1'b0 || err_code !== e.code || imem_addr !== exp_addr ||
                count !== exp_count) begin
                errors++;
                $display("FAIL %s_err_after: got ev=%b code=%b addr=%h cnt=%0d want 0 %b %h %0d",
                         name, err_valid, err_code, imem_addr, count, e.code, exp_addr,
                         exp_count);
            end
        end else begin
            checks++;
            if (imem_we !== 1'b1 || imem_addr !== e.addr || imem_wdata !== e.data) begin
                errors++;
                $display("FAIL %s_write: got we=%b addr=%h data=%h want 1 %h %h",
                         name, imem_we, imem_addr, imem_wdata, e.addr, e.data);
            end
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                checks++;
                if (imem_we !== 1'b1 || imem_addr !== e.addr || imem_wdata !== e.data ||
                    in_ready !== 1'b0 || count !== exp_count) begin
                    errors++;
                    $display("FAIL %s_hold: got we=%b addr=%h data=%h rdy=%b cnt=%0d want 1 %h %h 0 %0d",
                             name, imem_we, imem_addr, imem_wdata, in_ready, count, e.addr,
                             e.data, exp_count);
                end
            end
            imem_wready = 1'b1;
            @(posedge clk);
            #1;
            imem_wready = 1'b0;
            exp_addr  = exp_addr + ADDR_W'(4);
            exp_count = exp_count + ADDR_W'(1);
            checks++;
            if (imem_we !== 1'b0 || imem_addr !== exp_addr || count !== exp_count) begin
                errors++;
                $display("FAIL %s_done: got we=%b addr=%h cnt=%0d want 0 %h %0d",
                         name, imem_we, imem_addr, count, exp_addr, exp_count);
            end
        end
    endtask

    task automatic test_encode();
        do_txn("ldur", 3'd0, 5'd1, 5'd2, 5'd0, 64'd8, 1'b0, 2'b00, 32'hF8408041, 0);
        do_txn("cbz_hold", 3'd2, 5'd3, 5'd0, 5'd0, -64'sd2, 1'b0, 2'b00, 32'hB4FFFFC3, 3);
    endtask

    task automatic test_errors();
        do_txn("b_range", 3'd4, 5'd0, 5'd0, 5'd0, 64'h2000000, 1'b1, 2'b01, 32'h0, 0);
        do_txn("ldur_range", 3'd0, 5'd1, 5'd2, 5'd0, 64'd512, 1'b1, 2'b01, 32'h0, 0);
        do_txn("bad_fmt", 3'd6, 5'd1, 5'd2, 5'd3, 64'd0, 1'b1, 2'b10, 32'h0, 0);
        do_txn("stur_neg", 3'd1, 5'd1, 5'd2, 5'd0, -64'sd1, 1'b1, 2'b01, 32'h0, 0);
    endtask

    task automatic test_more_encode();
        do_txn("b_neg", 3'd4, 5'd0, 5'd0, 5'd0, -64'sd1, 1'b0, 2'b00, 32'h17FFFFFF, 0);
        do_txn("orr", 3'd3, 5'd5, 5'd6, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b00,
               32'hAA0700C5, 1);
    endtask

    task automatic test_full();
        checks++;
        if (full !== 1'b1 || in_ready !== 1'b0 || count !== 4) begin
            errors++;
            $display("FAIL full: got full=%b rdy=%b cnt=%0d want 1 0 4", full, in_ready, count);
        end
        in_valid = 1'b1;
        in_fmt   = 3'd0;
        in_imm   = 64'd4;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (imem_we !== 1'b0 || in_ready !== 1'b0 || count !== 4 || imem_addr !== 16) begin
            errors++;
            $display("FAIL full_block: got we=%b rdy=%b cnt=%0d addr=%h want 0 0 4 010",
                     imem_we, in_ready, count, imem_addr);
        end
        in_valid = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        exp_addr  = '0;
        exp_count = '0;
        checks++;
        if (full !== 1'b0 || in_ready !== 1'b1 || count !== 0 || imem_addr !== 0) begin
            errors++;
            $display("FAIL clr_full: got full=%b rdy=%b cnt=%0d addr=%h want 0 1 0 000",
                     full, in_ready, count, imem_addr);
        end
    endtask

    task automatic test_clr_write();
        do_txn("stur", 3'd1, 5'd9, 5'd10, 5'd0, 64'd511, 1'b0, 2'b00, 32'hF81FF149, 0);
        in_valid = 1'b1;
        in_fmt   = 3'd4;
        in_imm   = 64'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 4) begin
            errors++;
            $display("FAIL clr_write_setup: got we=%b addr=%h want 1 004", imem_we, imem_addr);
        end
        imem_wready = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        imem_wready = 1'b0;
        clr = 1'b0;
        exp_addr  = '0;
        exp_count = '0;
        checks++;
        if (imem_we !== 1'b0 || imem_addr !== 0 || count !== 0 || err_valid !== 1'b0 ||
            in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_write: got we=%b addr=%h cnt=%0d ev=%b rdy=%b want 0 000 0 0 1",
                     imem_we, imem_addr, count, err_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_write();
        do_txn("cbz_pos", 3'd2, 5'd31, 5'd0, 5'd0, 64'h3FFFF, 1'b0, 2'b00, 32'hB47FFFFF, 0);
        in_valid = 1'b1;
        in_fmt   = 3'd4;
        in_imm   = 64'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (imem_we !== 1'b1 || imem_wdata !== 32'h14000001) begin
            errors++;
            $display("FAIL rst_write_setup: got we=%b data=%h want 1 14000001",
                     imem_we, imem_wdata);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_we !== 1'b0 || imem_addr !== 0 || count !== 0 || imem_wdata !== 0 ||
            in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_write: got we=%b addr=%h cnt=%0d data=%h rdy=%b want 0 000 0 0 1",
                     imem_we, imem_addr, count, imem_wdata, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_addr  = '0;
        exp_count = '0;
    endtask

    initial begin
        test_reset();
        test_encode();
        test_errors();
        test_more_encode();
        test_full();
        test_clr_write();
        test_reset_mid_write();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
